regfile_bus: RTL and testbench
==============================

# regfile_bus

Register file and operand-bus stage directly upstream of the ALU in the downsampling processor. Holds eight 19-bit registers, drives the ALU's A and B operand buses from registered read ports, and writes ALU results and the zero flag back in the same clock domain. Also owns the program counter register, with auto-increment, so the control unit only issues select/enable strobes.

## Interface
- DATA_W, 19, datapath width; must match ALU operand width
- NREG, 8, register count; select width is clog2(NREG) = 3

- clk  input  1  rising-edge clock
- RST  input  1  reset; synchronous, active-high
- a_sel  input  3  A-bus source register
- b_sel  input  3  B-bus source register
- b_imm_en  input  1  1: B bus takes imm instead of register
- imm  input  19  immediate operand (ADDI/SUBI/SHL/SHR amounts)
- wb_en  input  1  write alu_out into register wb_sel this edge
- wb_sel  input  3  writeback destination
- alu_out  input  19  ALU result
- z_in  input  1  ALU zero flag
- z_we  input  1  latch z_in into z_q this edge
- pc_inc  input  1  increment R7 (PC) this edge
- a_bus  output  19  registered A operand to ALU a_in
- b_bus  output  19  registered B operand to ALU b_in
- z_q  output  1  registered zero flag for branch decisions
- pc_out  output  19  current R7 contents

## Operation
- Register map: R0 hard-wired zero (writes ignored, reads 0); R1–R6 general (R1 = AC by convention); R7 = PC.
- Read: every edge, a_bus <= src(a_sel); b_bus <= b_imm_en ? imm : src(b_sel).
- Write: on edge with wb_en=1 and wb_sel≠0, R[wb_sel] <= alu_out.
- PC: on edge with pc_inc=1, R7 <= R7 + 1, modulo 2^19 (0x7FFFF -> 0x00000, no carry out).
- PC conflict: wb_en=1, wb_sel=7 and pc_inc=1 same edge -> writeback wins, increment dropped.
- Zero flag: z_q <= z_in when z_we=1, else hold. z_we is independent of wb_en (compare-only ops set flag without writing).
- src(n) definition depends on REGFILE_BYPASS_EN (see Configuration); R0 always 0, never bypassed.
- No arithmetic other than PC increment; all widths DATA_W, no sign extension.

## Timing
- Reset: on edge with RST=1, R1–R7 = 0, a_bus = 0, b_bus = 0, z_q = 0, pc_out = 0. RST overrides wb_en, pc_inc, z_we on the same edge. Reset mid-operation discards any in-flight writeback.
- Read latency: selects sampled at edge N, operand stable on a_bus/b_bus after edge N, consumed by the (combinational) ALU, result written back at edge N+1 -> one ALU op per two cycles when dependent, one per cycle when independent.
- pc_out is the register value itself: reflects increment/write one edge after request.
- Same-edge write and read of same register: governed by bypass macro.
- a_sel and b_sel may select the same register; both buses get the identical value.

## Configuration
- REGFILE_BYPASS_EN defined: src(n) = alu_out when wb_en=1 and wb_sel=n≠0 on the same edge, also for n=7 when pc_inc collides (bypass value = alu_out); otherwise R[n]. Dependent ops issue back-to-back.
- Undefined: src(n) = R[n] pre-edge value; same-edge write not visible until next read. Control unit inserts one bubble between dependent ops.

## Test plan
- Reset: write R3=0x12345, then assert RST one cycle -> a_bus, b_bus, z_q, pc_out = 0 and R3 reads 0.
- R0 lock: wb_en=1, wb_sel=0, alu_out=0x7FFFF -> a_sel=0 next cycle gives a_bus=0.
- Immediate path: R2=0x00010, b_sel=2, b_imm_en=1, imm=0x00003 -> b_bus=0x00003; b_imm_en=0 -> b_bus=0x00010.
- PC wrap and conflict: R7=0x7FFFF, pc_inc=1 -> pc_out=0; pc_inc=1 with wb_sel=7, alu_out=0x00100 -> pc_out=0x00100.
- Bypass: R4=0x00005, same edge wb_en=1, wb_sel=4, alu_out=0x0000A, a_sel=4 -> a_bus=0x0000A with REGFILE_BYPASS_EN, 0x00005 without; following read 0x0000A in both.
- Flag: z_in=1, z_we=0 -> z_q stays 0; z_we=1 -> z_q=1; z_we=1, z_in=0 -> z_q=0.

Source files
------------

// File: rtl/regfile_bus.sv
// Eight-entry register file feeding the ALU operand buses, with zero-flag latch and R7 program counter.
// Optional macro REGFILE_BYPASS_EN forwards a same-edge writeback onto the operand buses.
module regfile_bus #(
    parameter int DATA_W = 19,
    parameter int NREG   = 8,
    parameter int SEL_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [SEL_W-1:0]  b_sel,
    input  logic              b_imm_en,
    input  logic [DATA_W-1:0] imm,
    input  logic              wb_en,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              z_in,
    input  logic              z_we,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] a_bus,
    output logic [DATA_W-1:0] b_bus,
    output logic              z_q,
    output logic [DATA_W-1:0] pc_out
);

    logic [DATA_W-1:0] rf_val [NREG];
    logic [DATA_W-1:0] a_src;
    logic [DATA_W-1:0] b_src;
    logic [DATA_W-1:0] a_bus_reg;
    logic [DATA_W-1:0] b_bus_reg;
    logic              z_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_val[gi] = '0;
            end else begin : g_reg
                localparam bit IS_PC = (gi == NREG - 1);
                logic [DATA_W-1:0] val_reg;
                logic [DATA_W-1:0] val_next;

                // Writeback is applied last so it beats a colliding PC increment.
                always_comb begin
                    val_next = val_reg;
                    if (IS_PC && pc_inc) begin
                        val_next = val_reg + DATA_W'(1);
                    end
                    if (wb_en && (wb_sel == SEL_W'(gi))) begin
                        val_next = alu_out;
                    end
                end

                always_ff @(posedge clk) begin
                    if (RST) begin
                        val_reg <= '0;
                    end else begin
                        val_reg <= val_next;
                    end
                end

                assign rf_val[gi] = val_reg;
            end
        end
    endgenerate

    always_comb begin
        a_src = rf_val[a_sel];
        b_src = rf_val[b_sel];
`ifdef REGFILE_BYPASS_EN
        // R0 is never forwarded: a write to it is discarded.
        if (wb_en && (wb_sel != '0)) begin
            if (wb_sel == a_sel) begin
                a_src = alu_out;
            end
            if (wb_sel == b_sel) begin
                b_src = alu_out;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            a_bus_reg <= '0;
            b_bus_reg <= '0;
            z_reg     <= 1'b0;
        end else begin
            a_bus_reg <= a_src;
            b_bus_reg <= b_imm_en ? imm : b_src;
            if (z_we) begin
                z_reg <= z_in;
            end
        end
    end

    assign a_bus  = a_bus_reg;
    assign b_bus  = b_bus_reg;
    assign z_q    = z_reg;
    assign pc_out = rf_val[NREG-1];

endmodule

// File: tb/tb_regfile_bus.sv
// Self-checking bench for regfile_bus: directed vector table followed by randomized cycles against a reference model.
module tb_regfile_bus;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RST;
    logic [2:0]  a_sel, b_sel, wb_sel;
    logic        b_imm_en, wb_en, z_in, z_we, pc_inc;
    logic [18:0] imm, alu_out;
    logic [18:0] a_bus, b_bus, pc_out;
    logic        z_q;

    int total = 0;
    int bad   = 0;

    regfile_bus dut (
        .clk(clk), .RST(RST), .a_sel(a_sel), .b_sel(b_sel), .b_imm_en(b_imm_en),
        .imm(imm), .wb_en(wb_en), .wb_sel(wb_sel), .alu_out(alu_out), .z_in(z_in),
        .z_we(z_we), .pc_inc(pc_inc), .a_bus(a_bus), .b_bus(b_bus), .z_q(z_q), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  a_sel, b_sel;
        logic        b_imm_en;
        logic [18:0] imm;
        logic        wb_en;
        logic [2:0]  wb_sel;
        logic [18:0] alu_out;
        logic        z_in, z_we, pc_inc;
        logic [18:0] exp_a, exp_b;
        logic        exp_z;
        logic [18:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] as, input logic [2:0] bs, input logic bi,
                       input logic [18:0] im, input logic we, input logic [2:0] ws, input logic [18:0] ao,
                       input logic zi, input logic zw, input logic pi, input logic [18:0] ea,
                       input logic [18:0] eb, input logic ez, input logic [18:0] ep);
        vec_t v;
        v.rst = r; v.a_sel = as; v.b_sel = bs; v.b_imm_en = bi; v.imm = im;
        v.wb_en = we; v.wb_sel = ws; v.alu_out = ao; v.z_in = zi; v.z_we = zw; v.pc_inc = pi;
        v.exp_a = ea; v.exp_b = eb; v.exp_z = ez; v.exp_pc = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [2:0] as, input logic [2:0] bs, input logic bi,
                         input logic [18:0] im, input logic we, input logic [2:0] ws, input logic [18:0] ao,
                         input logic zi, input logic zw, input logic pi);
        RST = r; a_sel = as; b_sel = bs; b_imm_en = bi; imm = im;
        wb_en = we; wb_sel = ws; alu_out = ao; z_in = zi; z_we = zw; pc_inc = pi;
    endtask

    task automatic check(input string name, input int idx, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got=%05h expected=%05h", name, idx, got, exp);
        end
    endtask

    // Reference model state, plain integers
    int          m_r [8];
    int          m_a, m_b, m_z;
    int          xa, xb;

    initial begin
        drive(1'b0, 3'd0, 3'd0, 1'b0, 19'd0, 1'b0, 3'd0, 19'd0, 1'b0, 1'b0, 1'b0);

        //   rst a  b  bi imm      we ws aluout    zi zw pi  exp_a                  exp_b     z  exp_pc
        add(1, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    1, 3, 19'h12345, 0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 3, 3, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h12345,             19'h12345,0, 19'h0);
        add(1, 3, 3, 0, 19'h0,    1, 5, 19'h11111, 1, 1, 1, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 3, 5, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    1, 0, 19'h7FFFF, 0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    1, 2, 19'h00010, 0, 0, 0, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 2, 1, 19'h3,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h3,    0, 19'h0);
        add(0, 0, 2, 0, 19'h3,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h10,   0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    1, 7, 19'h7FFFF, 0, 0, 0, 19'h0,                 19'h0,    0, 19'h7FFFF);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 1, 19'h0,                 19'h0,    0, 19'h0);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 1, 19'h0,                 19'h0,    0, 19'h1);
        add(0, 0, 0, 0, 19'h0,    1, 7, 19'h00100, 0, 0, 1, 19'h0,                 19'h0,    0, 19'h100);
        add(0, 0, 0, 0, 19'h0,    1, 4, 19'h00005, 0, 0, 0, 19'h0,                 19'h0,    0, 19'h100);
        add(0, 4, 0, 0, 19'h0,    1, 4, 19'h0000A, 0, 0, 0, BYP ? 19'hA : 19'h5,   19'h0,    0, 19'h100);
        add(0, 4, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'hA,                 19'h0,    0, 19'h100);
        add(0, 7, 0, 0, 19'h0,    1, 7, 19'h00200, 0, 0, 1, BYP ? 19'h200 : 19'h100, 19'h0, 0, 19'h200);
        add(0, 7, 7, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h200,               19'h200,  0, 19'h200);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     1, 0, 0, 19'h0,                 19'h0,    0, 19'h200);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     1, 1, 0, 19'h0,                 19'h0,    1, 19'h200);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h0,    1, 19'h200);
        add(0, 0, 0, 0, 19'h0,    0, 0, 19'h0,     0, 1, 0, 19'h0,                 19'h0,    0, 19'h200);
        add(0, 0, 6, 1, 19'h44,   1, 6, 19'h00333, 0, 0, 0, 19'h0,                 19'h44,   0, 19'h200);
        add(0, 0, 6, 0, 19'h55,   0, 0, 19'h0,     0, 0, 0, 19'h0,                 19'h333,  0, 19'h200);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].a_sel, vecs[i].b_sel, vecs[i].b_imm_en, vecs[i].imm,
                  vecs[i].wb_en, vecs[i].wb_sel, vecs[i].alu_out, vecs[i].z_in, vecs[i].z_we, vecs[i].pc_inc);
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: a=%05h b=%05h z=%0b pc=%05h", i, a_bus, b_bus, z_q, pc_out);
            check("vec_a_bus", i, a_bus, vecs[i].exp_a);
            check("vec_b_bus", i, b_bus, vecs[i].exp_b);
            check("vec_z_q", i, {18'd0, z_q}, {18'd0, vecs[i].exp_z});
            check("vec_pc_out", i, pc_out, vecs[i].exp_pc);
        end

        // Randomized cycles; first one is a reset so the model starts in a known state.
        for (int n = 0; n < 400; n++) begin
            logic        r, bi, we, zi, zw, pi;
            logic [2:0]  as, bs, ws;
            logic [18:0] im, ao;
            r  = (n == 0) || ($urandom_range(0, 31) == 0);
            as = 3'($urandom_range(0, 7));
            bs = 3'($urandom_range(0, 7));
            ws = ($urandom_range(0, 3) == 0) ? as : 3'($urandom_range(0, 7));
            bi = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            zi = 1'($urandom_range(0, 1));
            zw = 1'($urandom_range(0, 1));
            pi = 1'($urandom_range(0, 1));
            im = 19'($urandom);
            ao = ($urandom_range(0, 7) == 0) ? 19'h7FFFF : 19'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                m_r[7] = m_r[7];
            end
            drive(r, as, bs, bi, im, we, ws, ao, zi, zw, pi);

            if (r) begin
                for (int k = 0; k < 8; k++) m_r[k] = 0;
                m_a = 0; m_b = 0; m_z = 0;
            end else begin
                xa = (as == 0) ? 0 : ((BYP && we && ws == as) ? int'(ao) : m_r[as]);
                xb = (bs == 0) ? 0 : ((BYP && we && ws == bs) ? int'(ao) : m_r[bs]);
                m_a = xa;
                m_b = bi ? int'(im) : xb;
                if (zw) m_z = int'(zi);
                if (pi) m_r[7] = (m_r[7] + 1) % (1 << 19);
                if (we && ws != 0) m_r[ws] = int'(ao);
            end

            @(posedge clk);
            @(negedge clk);
            $display("rnd %0d: rst=%0b a_sel=%0d b_sel=%0d imm_en=%0b wb=%0b/%0d inc=%0b -> a=%05h b=%05h z=%0b pc=%05h",
                     n, r, as, bs, bi, we, ws, pi, a_bus, b_bus, z_q, pc_out);
            check("rnd_a_bus", n, a_bus, 19'(m_a));
            check("rnd_b_bus", n, b_bus, 19'(m_b));
            check("rnd_z_q", n, {18'd0, z_q}, 19'(m_z));
            check("rnd_pc_out", n, pc_out, 19'(m_r[7]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
